// File: rtl/control_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// control_pkg : shared types and encodings for the multi-cycle controller
// Revision    : 1.0
// ---------------------------------------------------------------------------
package control_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_OPIMM   = 3'd0,
        CLS_OP      = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } class_t;

    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_B = 3'b001;
    localparam logic [2:0] c_IMM_S = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;

    localparam logic [1:0] c_PC_PLUS4 = 2'b00;
    localparam logic [1:0] c_PC_IMM   = 2'b01;

    localparam logic [1:0] c_RES_ALU = 2'b00;
    localparam logic [1:0] c_RES_MEM = 2'b01;
    localparam logic [1:0] c_RES_PC4 = 2'b10;

    localparam logic [1:0] c_FAULT_NONE    = 2'b00;
    localparam logic [1:0] c_FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] c_FAULT_TIMEOUT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// control_decode : opcode/funct3 -> instruction class and ALU operand selects
// Revision       : 1.0
// ---------------------------------------------------------------------------
module control_decode
    import control_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] f3_i,
    output class_t     cls_o,
    output logic       legal_o,
    output logic       alusrc_o,
    output logic [2:0] immsrc_o,
    output logic [2:0] aluctrl_o
);

    always_comb begin
        cls_o     = CLS_ILLEGAL;
        legal_o   = 1'b0;
        alusrc_o  = 1'b0;
        immsrc_o  = c_IMM_I;
        aluctrl_o = 3'b000;
        case (op_i)
            c_OPC_OPIMM: begin
                cls_o     = CLS_OPIMM;
                legal_o   = 1'b1;
                alusrc_o  = 1'b1;
                aluctrl_o = f3_i;
            end
            c_OPC_OP: begin
                cls_o     = CLS_OP;
                legal_o   = 1'b1;
                aluctrl_o = f3_i;
            end
            c_OPC_LOAD: begin
                cls_o    = CLS_LOAD;
                legal_o  = 1'b1;
                alusrc_o = 1'b1;
            end
            c_OPC_STORE: begin
                cls_o    = CLS_STORE;
                legal_o  = 1'b1;
                alusrc_o = 1'b1;
                immsrc_o = c_IMM_S;
            end
            c_OPC_BRANCH: begin
                cls_o    = CLS_BRANCH;
                legal_o  = 1'b1;
                immsrc_o = c_IMM_B;
            end
            c_OPC_JAL: begin
                cls_o    = CLS_JAL;
                legal_o  = 1'b1;
                immsrc_o = c_IMM_J;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// control_fsm : multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with halt
// Revision    : 1.0
// ---------------------------------------------------------------------------
module control_fsm
    import control_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] instr,
    input  logic          instr_valid,
    input  logic          Eq,
    input  logic          mem_ready,
    output logic          IRWrite,
    output logic          PCWrite,
    output logic [1:0]    PCsrc,
    output logic          RegWrite,
    output logic [2:0]    ALUctrl,
    output logic          ALUsrc,
    output logic [2:0]    ImmSrc,
    output logic [1:0]    ResultSrc,
    output logic          MemReq,
    output logic          MemWrite,
    output logic          retire,
    output logic          halted,
    output logic [1:0]    fault
);

    localparam int             c_CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = '1;
    localparam logic [c_CW-1:0] c_TO      = c_CW'(TIMEOUT);

    state_t          state_q, state_d;
    logic [6:0]      op_q, op_d;
    logic [2:0]      f3_q, f3_d;
    logic [c_CW-1:0] wait_q, wait_d;
    logic [1:0]      fault_q, fault_d;

    class_t          w_cls;
    logic            w_legal;
    logic            w_alusrc;
    logic [2:0]      w_immsrc;
    logic [2:0]      w_aluctrl;
    logic [c_CW-1:0] w_wait_inc;
    logic            w_timeout;
    logic            w_taken;
    logic            w_unused;

    assign w_unused = ^{instr[AW-1:15], instr[11:7]};

    control_decode u_decode (
        .op_i      (op_q),
        .f3_i      (f3_q),
        .cls_o     (w_cls),
        .legal_o   (w_legal),
        .alusrc_o  (w_alusrc),
        .immsrc_o  (w_immsrc),
        .aluctrl_o (w_aluctrl)
    );

    // Timeout fires on the MEM cycle whose missing ack would bring the count to TIMEOUT.
    assign w_wait_inc = (wait_q == c_CNT_MAX) ? wait_q : wait_q + 1'b1;
    assign w_timeout  = (TIMEOUT != 0) && (w_wait_inc == c_TO);
    assign w_taken    = (f3_q == 3'b000) ? Eq : (f3_q == 3'b001) ? !Eq : 1'b0;
    assign fault      = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            op_q    <= '0;
            f3_q    <= '0;
            wait_q  <= '0;
            fault_q <= c_FAULT_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        f3_d      = f3_q;
        wait_d    = '0;
        fault_d   = fault_q;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCsrc     = c_PC_PLUS4;
        RegWrite  = 1'b0;
        ALUctrl   = 3'b000;
        ALUsrc    = 1'b0;
        ImmSrc    = c_IMM_I;
        ResultSrc = c_RES_ALU;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        case (state_q)
            FETCH: begin
                // rst_n gating keeps IRWrite low while reset is held with instr_valid high.
                if (instr_valid && rst_n) begin
                    IRWrite = 1'b1;
                    op_d    = instr[6:0];
                    f3_d    = instr[14:12];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (w_legal) begin
                    state_d = EXEC;
                end else begin
                    state_d = HALT;
                    fault_d = c_FAULT_ILLEGAL;
                end
            end
            EXEC: begin
                ALUsrc  = w_alusrc;
                ImmSrc  = w_immsrc;
                ALUctrl = w_aluctrl;
                case (w_cls)
                    CLS_BRANCH: begin
                        PCWrite = 1'b1;
                        PCsrc   = w_taken ? c_PC_IMM : c_PC_PLUS4;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    CLS_JAL: begin
                        RegWrite  = 1'b1;
                        ResultSrc = c_RES_PC4;
                        PCWrite   = 1'b1;
                        PCsrc     = c_PC_IMM;
                        retire    = 1'b1;
                        state_d   = FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = MEM;
                    default:             state_d = WB;
                endcase
            end
            MEM: begin
                ALUsrc   = w_alusrc;
                ImmSrc   = w_immsrc;
                ALUctrl  = w_aluctrl;
                MemReq   = 1'b1;
                MemWrite = (w_cls == CLS_STORE);
                if (mem_ready) begin
                    if (w_cls == CLS_STORE) begin
                        PCWrite = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (w_timeout) begin
                    state_d = HALT;
                    fault_d = c_FAULT_TIMEOUT;
                end else begin
                    wait_d = w_wait_inc;
                end
            end
            WB: begin
                RegWrite  = 1'b1;
                ResultSrc = (w_cls == CLS_LOAD) ? c_RES_MEM : c_RES_ALU;
                PCWrite   = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_control_fsm : randomized bench with a per-instruction behavioural model
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_control_fsm;

    localparam int TO = 4;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       rw;
        logic [2:0] aluc;
        logic       alus;
        logic [2:0] imms;
        logic [1:0] ress;
        logic       mreq;
        logic       mwr;
        logic       ret;
        logic       hlt;
        logic [1:0] flt;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid, Eq, mem_ready;
    logic        IRWrite, PCWrite, RegWrite, ALUsrc, MemReq, MemWrite, retire, halted;
    logic [1:0]  PCsrc, ResultSrc, fault;
    logic [2:0]  ALUctrl, ImmSrc;

    int    checks = 0;
    int    failures = 0;
    bit    chk_en = 1'b0;
    outs_t exp_q = '0;
    outs_t w_act;
    int    cyc = 0, last_len = 0, mreq_n = 0, ret_n = 0;
    logic [1:0] last_pcsrc = '0, last_fault = '0;

    control_fsm #(.AW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .Eq(Eq), .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
        .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .MemReq(MemReq), .MemWrite(MemWrite),
        .retire(retire), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    assign w_act = {IRWrite, PCWrite, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmSrc,
                    ResultSrc, MemReq, MemWrite, retire, halted, fault};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("outs", 32'(w_act), 32'(exp_q));
            if (IRWrite) begin
                cyc <= 1; mreq_n <= 0; ret_n <= 0;
            end else begin
                if (cyc > 0) cyc <= cyc + 1;
                if (MemReq) mreq_n <= mreq_n + 1;
                if (retire) begin
                    last_len   <= cyc + 1;
                    last_pcsrc <= PCsrc;
                    ret_n      <= ret_n + 1;
                end
            end
            if (halted) last_fault <= fault;
        end
    end

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op == 7'h13 || op == 7'h33 || op == 7'h03 || op == 7'h23 || op == 7'h63 || op == 7'h6F;
    endfunction

    // Operand selects that the datapath needs while an instruction is in EXEC/MEM.
    function automatic outs_t exec_sel(input logic [6:0] op, input logic [2:0] f3);
        outs_t e = '0;
        if (op == 7'h13)      begin e.alus = 1; e.aluc = f3; end
        else if (op == 7'h33) begin e.aluc = f3; end
        else if (op == 7'h03) begin e.alus = 1; end
        else if (op == 7'h23) begin e.alus = 1; e.imms = 3'b010; end
        else if (op == 7'h63) begin e.imms = 3'b001; end
        else if (op == 7'h6F) begin e.imms = 3'b011; end
        return e;
    endfunction

    task automatic drive(input outs_t e, input bit iv, input logic [31:0] ins,
                         input bit eqv, input bit rdy);
        exp_q = e; instr_valid = iv; instr = ins; Eq = eqv; mem_ready = rdy;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) drive('0, 1'b1, $urandom, rb(), rb());
        rst_n = 1'b1;
    endtask

    task automatic halt_cycles(input logic [1:0] f);
        outs_t e = '0;
        e.hlt = 1'b1; e.flt = f;
        repeat (3) drive(e, 1'b1, $urandom, rb(), rb());
    endtask

    // lat: MEM cycle (1-based) carrying mem_ready, 0 = never. abort: reset in 2nd MEM cycle.
    task automatic run_instr(input logic [31:0] ins, input bit eq, input int lat,
                             input int idle, input bit abort);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        outs_t e, base;
        bit taken, store;
        repeat (idle) drive('0, 1'b0, $urandom, rb(), rb());
        e = '0; e.irw = 1;
        drive(e, 1'b1, ins, rb(), rb());
        drive('0, rb(), $urandom, rb(), rb());
        if (!is_legal(op)) begin
            halt_cycles(2'b01);
            do_reset();
            return;
        end
        base = exec_sel(op, f3);
        e = base;
        if (op == 7'h63) begin
            taken = (f3 == 3'b000) ? eq : (f3 == 3'b001) ? !eq : 1'b0;
            e.pcw = 1; e.pcsrc = taken ? 2'b01 : 2'b00; e.ret = 1;
            drive(e, rb(), $urandom, eq, rb());
            return;
        end
        if (op == 7'h6F) begin
            e.rw = 1; e.ress = 2'b10; e.pcw = 1; e.pcsrc = 2'b01; e.ret = 1;
            drive(e, rb(), $urandom, eq, rb());
            return;
        end
        drive(e, rb(), $urandom, eq, rb());
        if (op == 7'h13 || op == 7'h33) begin
            e = '0; e.rw = 1; e.pcw = 1; e.ret = 1;
            drive(e, rb(), $urandom, rb(), rb());
            return;
        end
        store = (op == 7'h23);
        for (int k = 1; k <= TO; k++) begin
            e = base; e.mreq = 1; e.mwr = store;
            if (abort && k == 2) begin
                instr_valid = 1'b1; exp_q = '0;
                rst_n = 1'b0;
                #1;
                chk("abort_memreq", 32'(MemReq), 32'd0);
                do_reset();
                return;
            end
            if (k == lat) begin
                if (store) begin
                    e.pcw = 1; e.ret = 1;
                    drive(e, rb(), $urandom, rb(), 1'b1);
                end else begin
                    drive(e, rb(), $urandom, rb(), 1'b1);
                    e = '0; e.rw = 1; e.ress = 2'b01; e.pcw = 1; e.ret = 1;
                    drive(e, rb(), $urandom, rb(), rb());
                end
                return;
            end
            drive(e, rb(), $urandom, rb(), 1'b0);
        end
        halt_cycles(2'b10);
        do_reset();
    endtask

    initial begin
        logic [6:0]  ops [8];
        logic [31:0] ins;
        int          lat;
        bit          ab;
        ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h7F, 7'h63};
        rst_n = 1'b0; instr = '0; instr_valid = 1'b1; Eq = 1'b0; mem_ready = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        do_reset();

        run_instr(32'h00500093, 1'b0, 0, 2, 1'b0);
        chk("addi_len", 32'(last_len), 32'd4);
        run_instr(32'h00000063, 1'b1, 0, 0, 1'b0);
        chk("beq_pcsrc", 32'(last_pcsrc), 32'd1);
        chk("beq_len", 32'(last_len), 32'd3);
        run_instr(32'h00001063, 1'b1, 0, 0, 1'b0);
        chk("bne_pcsrc", 32'(last_pcsrc), 32'd0);
        run_instr(32'h00004063, 1'b1, 0, 1, 1'b0);
        chk("br100_pcsrc", 32'(last_pcsrc), 32'd0);
        run_instr(32'h00002103, 1'b0, 3, 1, 1'b0);
        chk("lw_len", 32'(last_len), 32'd7);
        chk("lw_memreq_cycles", 32'(mreq_n), 32'd3);
        run_instr(32'h00202023, 1'b0, 0, 0, 1'b0);
        chk("sw_to_memreq_cycles", 32'(mreq_n), 32'd4);
        chk("sw_to_retires", 32'(ret_n), 32'd0);
        chk("sw_to_fault", 32'(last_fault), 32'd2);
        run_instr(32'h00202023, 1'b0, 4, 0, 1'b0);
        chk("sw_len", 32'(last_len), 32'd7);
        chk("sw_retires", 32'(ret_n), 32'd1);
        run_instr(32'hFFFFFFFF, 1'b0, 0, 0, 1'b0);
        chk("illegal_fault", 32'(last_fault), 32'd1);
        run_instr(32'h00002103, 1'b0, 5, 0, 1'b1);
        run_instr(32'h00500093, 1'b0, 0, 0, 1'b0);
        chk("post_abort_len", 32'(last_len), 32'd4);

        for (int i = 0; i < 250; i++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 7)];
            lat = $urandom_range(0, 6);
            ab  = ($urandom_range(0, 9) == 0) && (lat == 0 || lat >= 3);
            run_instr(ins, rb(), lat, $urandom_range(0, 2), ab);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_fsm.md
# control_fsm

Multi-cycle controller for the reduced RISC-V core, replacing the single-cycle combinational decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the same datapath selects (RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc). It adds a data-memory handshake with a timeout, beq/bne selection by funct3, JAL, and a sticky halt on illegal opcode or memory timeout.

## Interface
- AW, 32: instruction width; only bits [14:0] are decoded.
- TIMEOUT, 16: maximum MEM wait in cycles; 0 disables the timeout.
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- instr  in  AW  instruction from instruction memory
- instr_valid  in  1  instr valid this cycle
- Eq  in  1  rs1 == rs2 from the comparator
- mem_ready  in  1  data-memory acknowledge
- IRWrite  out  1  latch instr into the instruction register
- PCWrite  out  1  update PC
- PCsrc  out  2  00 PC+4, 01 PC+imm
- RegWrite  out  1  register-file write enable
- ALUctrl  out  3  ALU operation
- ALUsrc  out  1  0 rs2, 1 immediate
- ImmSrc  out  3  000 I, 001 B, 010 S, 011 J
- ResultSrc  out  2  00 ALU, 01 memory data, 10 PC+4
- MemReq  out  1  data-memory request
- MemWrite  out  1  store qualifier on MemReq
- retire  out  1  one-cycle pulse on an instruction's final cycle
- halted  out  1  sticky halt
- fault  out  2  00 none, 01 illegal opcode, 10 memory timeout

## Operation
- Reset state: state = FETCH, op_q/f3_q/wait_cnt = 0, fault = 00. Every output is 0 during and after reset until the first instr_valid.
- Capture: op_q = instr[6:0] and f3_q = instr[14:12], registered on the FETCH cycle where instr_valid = 1. All later decoding uses op_q/f3_q, never the live instr.
- FETCH:
  - Hold while instr_valid = 0.
  - On instr_valid: IRWrite = 1, go to DECODE.
- DECODE: outputs 0. Classify op_q:
  - Legal: 0010011 OP-IMM, 0110011 OP, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL. Go to EXEC.
  - Anything else: go to HALT with fault = 01.
- EXEC, ALUsrc/ImmSrc/ALUctrl by class:
  - OP-IMM: ALUsrc = 1, ImmSrc = 000, ALUctrl = f3_q.
  - OP: ALUsrc = 0, ImmSrc = 000, ALUctrl = f3_q.
  - LOAD: ALUsrc = 1, ImmSrc = 000, ALUctrl = 000.
  - STORE: ALUsrc = 1, ImmSrc = 010, ALUctrl = 000.
  - BRANCH: ALUsrc = 0, ImmSrc = 001, ALUctrl = 000.
  - JAL: ImmSrc = 011, ALUsrc = 0, ALUctrl = 000.
- EXEC next state:
  - OP-IMM/OP: go to WB.
  - LOAD/STORE: go to MEM.
  - BRANCH: taken = (f3_q == 000) ? Eq : (f3_q == 001) ? !Eq : 0. PCWrite = 1, PCsrc = taken ? 01 : 00, retire = 1, go to FETCH.
  - JAL: RegWrite = 1, ResultSrc = 10, PCWrite = 1, PCsrc = 01, retire = 1, go to FETCH.
- MEM: MemReq = 1, MemWrite = (STORE). ALUsrc/ImmSrc/ALUctrl are held at their EXEC values. wait_cnt increments each MEM cycle without mem_ready.
  - mem_ready, STORE: PCWrite = 1, PCsrc = 00, retire = 1, go to FETCH.
  - mem_ready, LOAD: go to WB.
  - TIMEOUT != 0 and wait_cnt reaches TIMEOUT: go to HALT with fault = 10. mem_ready arriving in that same cycle wins.
- WB: RegWrite = 1, ResultSrc = 01 for LOAD else 00, PCWrite = 1, PCsrc = 00, retire = 1, go to FETCH. wait_cnt cleared.
- HALT: halted = 1, every other output 0, instr_valid ignored. Exit only via rst_n.
- Unlisted outputs are 0 in every state.

## Timing
- All outputs are combinational from state and op_q/f3_q, plus Eq in EXEC and mem_ready in MEM. There is no output register.
- Minimum cycles per instruction, counting from the instr_valid cycle:
  - BRANCH, JAL: 3
  - OP, OP-IMM: 4
  - STORE: 4 (mem_ready in the first MEM cycle)
  - LOAD: 5 (mem_ready in the first MEM cycle)
- Eq must be valid in the EXEC cycle. mem_ready is sampled every MEM cycle.
- MemReq stays high continuously from MEM entry until mem_ready or timeout.
- wait_cnt is $clog2(TIMEOUT+1) bits wide, saturating. It is 0 on MEM entry.
- rst_n deasserting mid-instruction (e.g. in MEM) drops every output, MemReq included, asynchronously. After reset the controller restarts in FETCH. No partial write completes.

## Structure
- control_pkg holds:
  - state_t enum: FETCH, DECODE, EXEC, MEM, WB, HALT
  - opcode localparams
  - ImmSrc, PCsrc, ResultSrc and fault encodings
- Sub-module control_decode: combinational op_q/f3_q → class, legal flag, ALUsrc/ImmSrc/ALUctrl. It is instantiated once. The FSM, counter and registers stay in control_fsm.

## Test plan
- addi x1,x0,5 (0x00500093) → IRWrite, then EXEC ALUsrc = 1/ALUctrl = 000, then WB RegWrite = 1/ResultSrc = 00/PCWrite = 1/PCsrc = 00/retire; 4 cycles.
- beq 0x00000063 with Eq = 1 → PCsrc = 01; bne 0x00001063 with Eq = 1 → PCsrc = 00; branch with f3 = 100 → PCsrc = 00; all with PCWrite = 1, RegWrite = 0.
- lw 0x00002103, mem_ready on the 3rd MEM cycle → MemReq high 3 cycles, MemWrite = 0, then WB ResultSrc = 01/RegWrite = 1; 7 cycles total.
- sw 0x00202023, TIMEOUT = 4, mem_ready never → MemReq/MemWrite high 4 cycles, then halted = 1, fault = 10, retire never asserted. Repeat with mem_ready on the 4th cycle → retire, no halt.
- instr 0xFFFFFFFF → halted = 1, fault = 01 after DECODE; later instr_valid ignored; rst_n low clears all outputs.
- rst_n pulsed low during LOAD's MEM → MemReq = 0 immediately; restart in FETCH; next addi completes normally.
